// File: rtl/playback_pkg.sv
// Shared types for the playback controller: FSM state encoding, BCD/time widths
// and the next-state function used by the top-level FSM.
package playback_pkg;

  localparam int BCD_W   = 4;
  localparam int TIME_W  = 3 * BCD_W;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'b000,
    ST_PLAYING  = 3'b001,
    ST_PAUSED   = 3'b010,
    ST_FINISHED = 3'b011,
    ST_RELOAD   = 3'b100
  } state_t;

  // Priority inside every state: stop > end_match > play.
  function automatic state_t next_state(input state_t cur, input logic play,
                                        input logic stop, input logic end_match,
                                        input logic loop_en);
    state_t v_next;
    v_next = cur;
    case (cur)
      ST_IDLE:     if (!stop && play) v_next = ST_RELOAD;
      ST_RELOAD:   v_next = ST_PLAYING;
      ST_PLAYING: begin
        if (stop)           v_next = ST_IDLE;
        else if (end_match) v_next = loop_en ? ST_RELOAD : ST_FINISHED;
        else if (play)      v_next = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (stop)      v_next = ST_IDLE;
        else if (play) v_next = ST_PLAYING;
      end
      ST_FINISHED: begin
        if (stop)      v_next = ST_IDLE;
        else if (play) v_next = ST_RELOAD;
      end
      default:     v_next = ST_IDLE;
    endcase
    return v_next;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus stability counter; emits a one-cycle pulse on an
// accepted rising level. After reset the button must be seen released first.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DEB_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_pulse
);

  localparam logic [DEB_W-1:0] LAST_CNT = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1, r_sync2;
  logic             r_level, r_armed, r_pulse;
  logic [DEB_W-1:0] r_cnt;
  logic             w_eff_level, w_change;

  // Until a released level is accepted, behave as if the button were held so a
  // press spanning reset can never produce a pulse.
  assign w_eff_level = r_level | ~r_armed;
  assign w_change    = r_sync2 ^ w_eff_level;
  assign btn_pulse   = r_pulse;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_armed <= 1'b0;
      r_pulse <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      r_pulse <= 1'b0;
      if (!w_change) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST_CNT) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_armed <= 1'b1;
        r_pulse <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/playback_controller.sv
// Playback sequencing FSM driving an external MM:SS BCD Timer.
// Define PLAYBACK_LOOP_EN to auto-repeat the track instead of stopping in FINISHED.
module playback_controller
  import playback_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DEB_W           = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               play_btn,
  input  logic               stop_btn,
  input  logic [BCD_W-1:0]   track_min,
  input  logic [BCD_W-1:0]   track_sec1,
  input  logic [BCD_W-1:0]   track_sec0,
  input  logic [BCD_W-1:0]   minutes0,
  input  logic [BCD_W-1:0]   seconds1,
  input  logic [BCD_W-1:0]   seconds0,
  output logic               timer_count,
  output logic               timer_reset,
  output logic               playing,
  output logic               finished,
  output logic [STATE_W-1:0] state
);

`ifdef PLAYBACK_LOOP_EN
  localparam logic LOOP_EN = 1'b1;
`else
  localparam logic LOOP_EN = 1'b0;
`endif

  state_t            r_state;
  logic [TIME_W-1:0] r_len;
  logic              r_timer_reset, r_playing, r_finished;
  logic              w_play, w_stop, w_end_match;
  state_t            w_next;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DEB_W(DEB_W)) u_play_deb (
    .clk(clk), .reset(reset), .btn_raw(play_btn), .btn_pulse(w_play)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DEB_W(DEB_W)) u_stop_deb (
    .clk(clk), .reset(reset), .btn_raw(stop_btn), .btn_pulse(w_stop)
  );

  assign w_end_match = ({minutes0, seconds1, seconds0} == r_len);
  assign w_next      = next_state(r_state, w_play, w_stop, w_end_match, LOOP_EN);

  // Combinational so the Timer freezes on the very cycle it reaches the length.
  assign timer_count = (r_state == ST_PLAYING) & ~w_end_match;
  assign timer_reset = r_timer_reset;
  assign playing     = r_playing;
  assign finished    = r_finished;
  assign state       = r_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_len         <= '0;
      r_timer_reset <= 1'b0;
      r_playing     <= 1'b0;
      r_finished    <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_timer_reset <= (w_next != ST_IDLE) && (w_next != ST_RELOAD);
      r_playing     <= (w_next == ST_PLAYING);
`ifdef PLAYBACK_LOOP_EN
      r_finished    <= (r_state == ST_PLAYING) && (w_next == ST_RELOAD);
`else
      r_finished    <= (w_next == ST_FINISHED);
`endif
      // Length is captured only when starting from IDLE; replays keep it.
      if ((r_state == ST_IDLE) && (w_next == ST_RELOAD))
        r_len <= {track_min, track_sec1, track_sec0};
    end
  end

endmodule

// File: tb/tb_playback_controller.sv
// Directed bench for playback_controller with a BCD MM:SS Timer model.
// Expectations follow the PLAYBACK_LOOP_EN build setting.
module tb_playback_controller;
  import playback_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       play_btn = 1'b0;
  logic       stop_btn = 1'b0;
  logic [3:0] track_min = 4'd0, track_sec1 = 4'd0, track_sec0 = 4'd0;
  logic [3:0] t_min = 4'd0, t_s1 = 4'd0, t_s0 = 4'd0;
  logic       timer_count, timer_reset, playing, finished;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;

  playback_controller #(.DEBOUNCE_CYCLES(4), .DEB_W(16)) dut (
    .clk(clk), .reset(reset), .play_btn(play_btn), .stop_btn(stop_btn),
    .track_min(track_min), .track_sec1(track_sec1), .track_sec0(track_sec0),
    .minutes0(t_min), .seconds1(t_s1), .seconds0(t_s0),
    .timer_count(timer_count), .timer_reset(timer_reset),
    .playing(playing), .finished(finished), .state(state)
  );

  always #5 clk = ~clk;

  // External Timer: synchronous active-low clear, BCD count enable.
  always @(posedge clk) begin
    if (!timer_reset) begin
      t_min <= 4'd0; t_s1 <= 4'd0; t_s0 <= 4'd0;
    end else if (timer_count) begin
      if (t_s0 == 4'd9) begin
        t_s0 <= 4'd0;
        if (t_s1 == 4'd5) begin
          t_s1  <= 4'd0;
          t_min <= (t_min == 4'd9) ? 4'd0 : t_min + 4'd1;
        end else begin
          t_s1 <= t_s1 + 4'd1;
        end
      end else begin
        t_s0 <= t_s0 + 4'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("check %s: %0h ok", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the selected buttons 7 edges (action lands on edge 7), then release and
  // wait until the release is accepted (edge 13 after the press).
  task automatic press(input logic do_play, input logic do_stop);
    play_btn = do_play;
    stop_btn = do_stop;
    repeat (7) tick();
    play_btn = 1'b0;
    stop_btn = 1'b0;
    repeat (6) tick();
  endtask

  function automatic logic [15:0] tval();
    return 16'({t_min, t_s1, t_s0});
  endfunction

`ifdef PLAYBACK_LOOP_EN
  localparam int N_ITER = 3;
`else
  localparam int N_ITER = 1;
`endif

  initial begin
    #2 reset = 1'b0;
    track_min = 4'd0; track_sec1 = 4'd0; track_sec0 = 4'd5;
    repeat (3) tick();
    check("rst_state", 16'(state), 16'(ST_IDLE));
    check("rst_treset", 16'(timer_reset), 16'd0);
    check("rst_tcount", 16'(timer_count), 16'd0);
    check("rst_playing", 16'(playing), 16'd0);
    check("rst_finished", 16'(finished), 16'd0);
    reset = 1'b1;
    repeat (8) tick();

    // 3-cycle glitch must be rejected
    play_btn = 1'b1;
    repeat (3) tick();
    play_btn = 1'b0;
    repeat (10) tick();
    check("glitch_state", 16'(state), 16'(ST_IDLE));

    // Press held 10 cycles: pulse after 6 edges, RELOAD on edge 7
    play_btn = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("lat_idle", 16'(state), 16'(ST_IDLE));
    end
    tick();
    check("e7_reload", 16'(state), 16'(ST_RELOAD));
    check("e7_treset", 16'(timer_reset), 16'd0);
    check("e7_tcount", 16'(timer_count), 16'd0);
    tick();
    check("e8_playing", 16'(state), 16'(ST_PLAYING));
    check("e8_treset", 16'(timer_reset), 16'd1);
    check("e8_tcount", 16'(timer_count), 16'd1);
    check("e8_playflag", 16'(playing), 16'd1);
    check("e8_timer", tval(), 16'h000);
    track_sec0 = 4'd9;
    repeat (2) tick();
    play_btn = 1'b0;
    check("e10_timer", tval(), 16'h002);
    repeat (3) tick();
    check("end_timer", tval(), 16'h005);
    check("end_tcount", 16'(timer_count), 16'd0);
    check("end_state", 16'(state), 16'(ST_PLAYING));
    tick();
`ifdef PLAYBACK_LOOP_EN
    check("end_next", 16'(state), 16'(ST_RELOAD));
    check("end_finpulse", 16'(finished), 16'd1);
    press(1'b0, 1'b1);
    check("loop_stop", 16'(state), 16'(ST_IDLE));
`else
    check("fin_state", 16'(state), 16'(ST_FINISHED));
    check("fin_flag", 16'(finished), 16'd1);
    check("fin_playflag", 16'(playing), 16'd0);
    check("fin_timer", tval(), 16'h005);
    repeat (10) tick();
    check("fin_hold_state", 16'(state), 16'(ST_FINISHED));
    check("fin_hold_timer", tval(), 16'h005);

    // Replay from FINISHED keeps 0:05 although inputs now say 0:09
    play_btn = 1'b1;
    repeat (7) tick();
    check("replay_reload", 16'(state), 16'(ST_RELOAD));
    play_btn = 1'b0;
    tick();
    check("replay_timer0", tval(), 16'h000);
    repeat (5) tick();
    check("replay_timer5", tval(), 16'h005);
    tick();
    check("replay_fin", 16'(state), 16'(ST_FINISHED));
    press(1'b0, 1'b1);
    check("stop_idle", 16'(state), 16'(ST_IDLE));
    check("stop_treset", 16'(timer_reset), 16'd0);
`endif

    // Pause and resume with a long track
    track_min = 4'd1; track_sec1 = 4'd3; track_sec0 = 4'd0;
    press(1'b1, 1'b0);
    check("run_state", 16'(state), 16'(ST_PLAYING));
    check("run_timer", tval(), 16'h005);
    press(1'b1, 1'b0);
    check("pause_state", 16'(state), 16'(ST_PAUSED));
    check("pause_timer", tval(), 16'h012);
    check("pause_tcount", 16'(timer_count), 16'd0);
    check("pause_treset", 16'(timer_reset), 16'd1);
    press(1'b1, 1'b0);
    check("resume_state", 16'(state), 16'(ST_PLAYING));
    check("resume_timer", tval(), 16'h018);

    // Simultaneous play+stop: stop wins
    press(1'b1, 1'b1);
    check("both_state", 16'(state), 16'(ST_IDLE));
    check("both_treset", 16'(timer_reset), 16'd0);
    check("both_tcount", 16'(timer_count), 16'd0);

`ifndef PLAYBACK_LOOP_EN
    // Zero-length track finishes without ever counting
    track_min = 4'd0; track_sec1 = 4'd0; track_sec0 = 4'd0;
    play_btn = 1'b1;
    repeat (7) tick();
    check("zero_reload", 16'(state), 16'(ST_RELOAD));
    play_btn = 1'b0;
    tick();
    check("zero_playing", 16'(state), 16'(ST_PLAYING));
    check("zero_tcount", 16'(timer_count), 16'd0);
    tick();
    check("zero_fin", 16'(state), 16'(ST_FINISHED));
    repeat (4) tick();
    press(1'b0, 1'b1);
    check("zero_stop", 16'(state), 16'(ST_IDLE));
`endif

    // 0:03 track: stops once, or loops three times when auto-repeat is built in
    track_min = 4'd0; track_sec1 = 4'd0; track_sec0 = 4'd3;
    play_btn = 1'b1;
    repeat (7) tick();
    check("l_reload", 16'(state), 16'(ST_RELOAD));
    check("l_fin_from_idle", 16'(finished), 16'd0);
    play_btn = 1'b0;
    tick();
    check("l_playing", 16'(state), 16'(ST_PLAYING));
    for (int i = 0; i < N_ITER; i++) begin
      repeat (3) tick();
      check("l_timer3", tval(), 16'h003);
      check("l_tcount", 16'(timer_count), 16'd0);
      tick();
`ifdef PLAYBACK_LOOP_EN
      check("l_again_reload", 16'(state), 16'(ST_RELOAD));
      check("l_fin_pulse", 16'(finished), 16'd1);
      check("l_playflag", 16'(playing), 16'd0);
      tick();
      check("l_again_play", 16'(state), 16'(ST_PLAYING));
      check("l_fin_low", 16'(finished), 16'd0);
      check("l_timer0", tval(), 16'h000);
`else
      check("l_fin", 16'(state), 16'(ST_FINISHED));
`endif
    end
    press(1'b0, 1'b1);
    check("l_stop", 16'(state), 16'(ST_IDLE));

    // Async reset while PAUSED, with play held through reset
    track_min = 4'd1; track_sec1 = 4'd3; track_sec0 = 4'd0;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("pre_rst_paused", 16'(state), 16'(ST_PAUSED));
    play_btn = 1'b1;
    #3 reset = 1'b0;
    #1;
    check("arst_state", 16'(state), 16'(ST_IDLE));
    check("arst_treset", 16'(timer_reset), 16'd0);
    check("arst_tcount", 16'(timer_count), 16'd0);
    check("arst_playing", 16'(playing), 16'd0);
    check("arst_finished", 16'(finished), 16'd0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (15) tick();
    check("held_no_pulse", 16'(state), 16'(ST_IDLE));
    play_btn = 1'b0;
    repeat (8) tick();
    press(1'b1, 1'b0);
    check("repress_playing", 16'(state), 16'(ST_PLAYING));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
